csa_tree_accumulator: RTL and testbench
=======================================

Name: csa_tree_accumulator

Overview:
Multi-operand, multi-beat accumulator for the separable-convolution datapath.
- Each accepted beat compresses NUM_OPS unsigned operands plus the running redundant (sum, carry) pair through a 3:2 carry-save tree.
- After BEATS accepted beats, one carry-propagate add resolves the total, which is presented on a valid/ready output.
- Sits after the tap multipliers and sums one window per output pixel.

Parameters:
XLEN, 8, width of each input operand (unsigned)
NUM_OPS, 3, operands per beat; must be >= 1
BEATS, 3, beats accumulated per result; must be >= 1
ACC_XLEN, XLEN + $clog2(NUM_OPS*BEATS) + 1, width of internal redundant registers and CPA
OUT_XLEN, ACC_XLEN, width of out_sum; must be <= ACC_XLEN

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  beat operands valid
in_ready  out  1  block accepts a beat this cycle
in_ops  in  NUM_OPS*XLEN  packed operands, op k at [k*XLEN +: XLEN]
out_valid  out  1  out_sum holds a completed result
out_ready  in  1  consumer takes result
out_sum  out  OUT_XLEN  resolved accumulation result

Behaviour:
- Reset: state=ACCUM, acc_sum=0, acc_carry=0, beat_cnt=0, out_valid=0, out_sum=0. Reset wins over every other event in the same cycle.
- FSM states: ACCUM, RESOLVE.
- ACCUM:
  - in_ready=1; a beat is accepted when in_valid & in_ready.
  - On accept, the operands are zero-extended to ACC_XLEN.
  - The tree reduces {ops, acc_sum, acc_carry} to (s, c).
  - c is shifted left 1 at each 3:2 level. Bits beyond ACC_XLEN are dropped (arithmetic mod 2^ACC_XLEN; exact because ACC_XLEN covers full growth).
  - acc_sum<=s, acc_carry<=c, beat_cnt++.
  - When the beat with beat_cnt==BEATS-1 is accepted: beat_cnt<=0 and go to RESOLVE.
  - No accept: registers hold.
- RESOLVE:
  - in_ready=0.
  - If !out_valid | out_ready: out_sum <= acc_sum + acc_carry (low OUT_XLEN bits), out_valid<=1, acc_sum<=0, acc_carry<=0, state<=ACCUM.
  - Otherwise stall in RESOLVE with all registers held.
- Output:
  - out_valid & out_ready with no new load in the same cycle clears out_valid.
  - Load and consume in the same cycle leaves out_valid=1 with the new value.
  - out_sum is stable while out_valid & !out_ready.
- Latency: last beat accepted in cycle t -> out_valid=1 in cycle t+2 if the output is free.
- Throughput: BEATS accepted beats per BEATS+1 cycles; the next frame's beats are accepted while the previous result waits.
- BEATS==1: every accepted beat is followed by one RESOLVE cycle.
- in_ops is ignored when not accepted.
- No combinational path from out_ready to in_ready.

Optional Feature:
Macro: CSA_TREE_SATURATE_EN.
- Defined:
  - If the full ACC_XLEN CPA result exceeds 2^OUT_XLEN-1, out_sum = all ones.
  - Adds output port out_sat (1 bit); out_sat=1 with that result, reset 0, same timing and hold rules as out_sum.
- Not defined: out_sum is the low OUT_XLEN bits (wrap) and there is no out_sat port.

Decomposition:
- Shared package csa_pkg:
  - function clog2-based width helper for ACC_XLEN.
  - function computing the 3:2 tree depth for (NUM_OPS+2) inputs.
  - typedef of the FSM state enum {ACCUM, RESOLVE}.
- Sub-module csa_tree: purely combinational reduction of M ACC_XLEN-bit operands to (s, c), built from the existing 3:2 carry-save adder cell.
- The top module holds FSM, counter, registers and CPA.

Test Plan:
- XLEN=8, NUM_OPS=3, BEATS=3; ops all 255 for 3 beats, out_ready=1 -> out_sum=2295, out_valid two cycles after the 3rd accept, high one cycle.
- Beat 1 {1,2,3}, beat 2 {4,5,6}, beat 3 {7,8,9}, with in_valid gaps between beats -> out_sum=45; gaps do not advance beat_cnt.
- out_ready=0 across two full frames ({1,1,1}x3 then {2,2,2}x3) -> first out_sum=9 held stable; FSM stalls in RESOLVE with in_ready=0; after out_ready=1, second result 18 appears next cycle.
- Assert rst after 2 beats of a frame -> all outputs 0; the next 3 beats {10,10,10} give 90, with no residue from the aborted frame.
- BEATS=1, ops {0,0,0} then {255,0,1} back to back -> results 0 then 256; in_ready toggles 1,0,1,0.
- CSA_TREE_SATURATE_EN, OUT_XLEN=10, ops all 255 x3 beats -> out_sum=1023, out_sat=1; without macro -> out_sum=2295 mod 1024=247.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared types and elaboration-time helpers for the carry-save tree accumulator.
package csa_pkg;

  typedef enum logic {ACCUM, RESOLVE} state_t;

  // Internal width that holds NUM_OPS*BEATS operands of XLEN bits without overflow.
  function automatic int unsigned acc_width(input int unsigned xlen,
                                            input int unsigned nops,
                                            input int unsigned beats);
    return xlen + $clog2(nops * beats) + 1;
  endfunction

  // Number of operands remaining after `lvl` levels of 3:2 compression.
  function automatic int unsigned level_ops(input int unsigned n, input int unsigned lvl);
    int unsigned k;
    k = n;
    for (int unsigned i = 0; i < lvl; i++) k = (k / 3) * 2 + k % 3;
    return k;
  endfunction

  function automatic int unsigned tree_depth(input int unsigned n);
    int unsigned k;
    int unsigned d;
    k = n;
    d = 0;
    while (k > 2) begin
      k = (k / 3) * 2 + k % 3;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/csa_tree.sv
// Combinational 3:2 carry-save reduction of M W-bit operands to a (sum, carry) pair.
module csa_cell #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);
  assign s = a ^ b ^ d;
  // Carry is pre-shifted; the top carry-out falls off (mod 2^W arithmetic).
  assign c = ((a & b) | (a & d) | (b & d)) << 1;
endmodule

module csa_tree
  import csa_pkg::*;
#(
  parameter int unsigned M = 5,
  parameter int unsigned W = 13
) (
  input  logic [M*W-1:0] ops,
  output logic [W-1:0]   s,
  output logic [W-1:0]   c
);
  localparam int unsigned DEPTH = tree_depth(M);

  logic [W-1:0] lv [DEPTH+1][M];

  for (genvar i = 0; i < M; i++) begin : g_in
    assign lv[0][i] = ops[i*W +: W];
  end

  // Each level groups operands in threes; leftovers pass straight to the next level.
  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int unsigned N = level_ops(M, l);
    localparam int unsigned G = N / 3;
    localparam int unsigned R = N % 3;
    for (genvar g = 0; g < G; g++) begin : g_grp
      csa_cell #(.W(W)) u_cell (
        .a(lv[l][3*g]),
        .b(lv[l][3*g+1]),
        .d(lv[l][3*g+2]),
        .s(lv[l+1][2*g]),
        .c(lv[l+1][2*g+1])
      );
    end
    for (genvar r = 0; r < R; r++) begin : g_pass
      assign lv[l+1][2*G+r] = lv[l][3*G+r];
    end
  end

  assign s = lv[DEPTH][0];
  assign c = lv[DEPTH][1];
endmodule

// File: rtl/csa_tree_accumulator.sv
// Multi-beat carry-save accumulator with a single resolving add per frame.
// Optional CSA_TREE_SATURATE_EN clamps out_sum to all ones and adds out_sat.
module csa_tree_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned XLEN     = 8,
  parameter int unsigned NUM_OPS  = 3,
  parameter int unsigned BEATS    = 3,
  parameter int unsigned ACC_XLEN = acc_width(XLEN, NUM_OPS, BEATS),
  parameter int unsigned OUT_XLEN = ACC_XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_OPS*XLEN-1:0] in_ops,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_XLEN-1:0]     out_sum
`ifdef CSA_TREE_SATURATE_EN
  ,
  output logic                    out_sat
`endif
);
  localparam int unsigned M  = NUM_OPS + 2;
  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t                state;
  logic [ACC_XLEN-1:0]   acc_sum;
  logic [ACC_XLEN-1:0]   acc_carry;
  logic [CW-1:0]         beat_cnt;
  logic [M*ACC_XLEN-1:0] tree_in;
  logic [ACC_XLEN-1:0]   tree_s;
  logic [ACC_XLEN-1:0]   tree_c;
  logic [ACC_XLEN-1:0]   cpa;
  logic                  last_beat;

  always_comb begin
    tree_in = '0;
    for (int unsigned k = 0; k < NUM_OPS; k++)
      tree_in[k*ACC_XLEN +: ACC_XLEN] = ACC_XLEN'(in_ops[k*XLEN +: XLEN]);
    tree_in[NUM_OPS*ACC_XLEN +: ACC_XLEN]     = acc_sum;
    tree_in[(NUM_OPS+1)*ACC_XLEN +: ACC_XLEN] = acc_carry;
  end

  csa_tree #(.M(M), .W(ACC_XLEN)) u_tree (
    .ops(tree_in),
    .s  (tree_s),
    .c  (tree_c)
  );

  assign cpa       = acc_sum + acc_carry;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));
  assign in_ready  = (state == ACCUM);

`ifdef CSA_TREE_SATURATE_EN
  logic sat_hit;
  assign sat_hit = ((cpa >> OUT_XLEN) != '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc_sum   <= '0;
      acc_carry <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef CSA_TREE_SATURATE_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc_sum   <= tree_s;
            acc_carry <= tree_c;
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= RESOLVE;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
        RESOLVE: begin
          // A load here also covers a same-cycle consume: out_valid stays high.
          if (!out_valid || out_ready) begin
`ifdef CSA_TREE_SATURATE_EN
            out_sum <= sat_hit ? '1 : cpa[OUT_XLEN-1:0];
            out_sat <= sat_hit;
`else
            out_sum <= cpa[OUT_XLEN-1:0];
`endif
            out_valid <= 1'b1;
            acc_sum   <= '0;
            acc_carry <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_tree_accumulator.sv
// Self-checking bench for csa_tree_accumulator: directed table, corner sequences, random scoreboard.
module tb_csa_tree_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default configuration: XLEN=8, NUM_OPS=3, BEATS=3, ACC_XLEN=13
  logic        a_iv, a_ir, a_ov, a_or;
  logic [23:0] a_ops;
  logic [12:0] a_sum;

  // BEATS=1: ACC_XLEN = 8 + clog2(3) + 1 = 11
  logic        b_iv, b_ir, b_ov, b_or;
  logic [23:0] b_ops;
  logic [10:0] b_sum;

  // OUT_XLEN=10 narrowing
  logic        c_iv, c_ir, c_ov, c_or;
  logic [23:0] c_ops;
  logic [9:0]  c_sum;
`ifdef CSA_TREE_SATURATE_EN
  logic a_sat, b_sat, c_sat;
`endif

  csa_tree_accumulator #(.XLEN(8), .NUM_OPS(3), .BEATS(3)) u0 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_ops(a_ops),
    .out_valid(a_ov), .out_ready(a_or), .out_sum(a_sum)
`ifdef CSA_TREE_SATURATE_EN
    , .out_sat(a_sat)
`endif
  );

  csa_tree_accumulator #(.XLEN(8), .NUM_OPS(3), .BEATS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_ops(b_ops),
    .out_valid(b_ov), .out_ready(b_or), .out_sum(b_sum)
`ifdef CSA_TREE_SATURATE_EN
    , .out_sat(b_sat)
`endif
  );

  csa_tree_accumulator #(.XLEN(8), .NUM_OPS(3), .BEATS(3), .OUT_XLEN(10)) u2 (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_ops(c_ops),
    .out_valid(c_ov), .out_ready(c_or), .out_sum(c_sum)
`ifdef CSA_TREE_SATURATE_EN
    , .out_sat(c_sat)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no event expected event within bound", nm);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int o0, input int o1, input int o2);
    int n;
    a_iv  = 1'b1;
    a_ops = {8'(o2), 8'(o1), 8'(o0)};
    n = 0;
    while (!a_ir && n < 20) begin
      step;
      n++;
    end
    if (n == 20) fail_evt("in_ready_timeout");
    step;
    a_iv  = 1'b0;
    a_ops = 24'($urandom);
  endtask

  typedef struct {
    int op[9];
    int gap;
    int exp;
  } vec_t;
  vec_t tbl[5];

  // Scoreboard: frame sums computed with plain integer arithmetic
  logic rand_on = 1'b0;
  int   racc = 0;
  int   rcnt = 0;
  int   rseen = 0;
  int   q[$];

  always @(negedge clk) begin
    if (rand_on) begin
      if (a_ov && a_or) begin
        if (q.size() == 0) fail_evt("rand_unexpected_result");
        else begin
          chk("rand_sum", 32'(a_sum), 32'(q.pop_front()));
          rseen++;
        end
      end
      if (a_iv && a_ir) begin
        racc += int'(a_ops[7:0]) + int'(a_ops[15:8]) + int'(a_ops[23:16]);
        rcnt++;
        if (rcnt == 3) begin
          q.push_back(racc % 8192);
          racc = 0;
          rcnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0].op = '{255, 255, 255, 255, 255, 255, 255, 255, 255}; tbl[0].gap = 0; tbl[0].exp = 2295;
    tbl[1].op = '{1, 2, 3, 4, 5, 6, 7, 8, 9};                   tbl[1].gap = 2; tbl[1].exp = 45;
    tbl[2].op = '{10, 10, 10, 10, 10, 10, 10, 10, 10};          tbl[2].gap = 1; tbl[2].exp = 90;
    tbl[3].op = '{0, 0, 0, 0, 0, 0, 0, 0, 0};                   tbl[3].gap = 0; tbl[3].exp = 0;
    tbl[4].op = '{200, 17, 3, 99, 128, 64, 1, 250, 33};         tbl[4].gap = 3; tbl[4].exp = 795;

    rst = 1'b1;
    a_iv = 1'b0; a_or = 1'b1; a_ops = '0;
    b_iv = 1'b0; b_or = 1'b1; b_ops = '0;
    c_iv = 1'b0; c_or = 1'b1; c_ops = '0;
    repeat (3) step;
    rst = 1'b0;
    chk("reset_out_valid", 32'(a_ov), 0);
    chk("reset_out_sum", 32'(a_sum), 0);
    chk("reset_in_ready", 32'(a_ir), 1);
    chk("reset_b_out_valid", 32'(b_ov), 0);
    chk("reset_c_out_sum", 32'(c_sum), 0);

    // Table: three beats per frame, optional idle gaps, result checked for latency and value
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 3; b++) begin
        send_beat(tbl[i].op[3*b], tbl[i].op[3*b+1], tbl[i].op[3*b+2]);
        if (b < 2) repeat (tbl[i].gap) step;
      end
      chk("tbl_valid_early", 32'(a_ov), 0);
      chk("tbl_resolve_in_ready", 32'(a_ir), 0);
      step;
      chk("tbl_valid", 32'(a_ov), 1);
      chk("tbl_sum", 32'(a_sum), 32'(tbl[i].exp));
      step;
      chk("tbl_valid_one_cycle", 32'(a_ov), 0);
    end

    // Backpressure across two frames
    a_or = 1'b0;
    repeat (3) send_beat(1, 1, 1);
    step;
    chk("stall_first_valid", 32'(a_ov), 1);
    chk("stall_first_sum", 32'(a_sum), 9);
    repeat (3) send_beat(2, 2, 2);
    repeat (3) begin
      chk("stall_in_ready", 32'(a_ir), 0);
      chk("stall_valid_held", 32'(a_ov), 1);
      chk("stall_sum_held", 32'(a_sum), 9);
      step;
    end
    a_or = 1'b1;
    step;
    chk("stall_second_valid", 32'(a_ov), 1);
    chk("stall_second_sum", 32'(a_sum), 18);
    step;
    chk("stall_drained", 32'(a_ov), 0);

    // Reset in the middle of a frame
    send_beat(5, 5, 5);
    send_beat(5, 5, 5);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(a_ov), 0);
    chk("midrst_out_sum", 32'(a_sum), 0);
    chk("midrst_in_ready", 32'(a_ir), 1);
    repeat (3) send_beat(10, 10, 10);
    step;
    chk("midrst_valid", 32'(a_ov), 1);
    chk("midrst_sum", 32'(a_sum), 90);
    step;

    // BEATS=1 back to back
    b_iv = 1'b1; b_ops = '0;
    chk("b1_ready0", 32'(b_ir), 1);
    step;
    chk("b1_ready1", 32'(b_ir), 0);
    step;
    chk("b1_ready2", 32'(b_ir), 1);
    chk("b1_valid0", 32'(b_ov), 1);
    chk("b1_sum0", 32'(b_sum), 0);
    b_ops = {8'd1, 8'd0, 8'd255};
    step;
    b_iv = 1'b0;
    chk("b1_ready3", 32'(b_ir), 0);
    chk("b1_consumed", 32'(b_ov), 0);
    step;
    chk("b1_ready4", 32'(b_ir), 1);
    chk("b1_valid1", 32'(b_ov), 1);
    chk("b1_sum1", 32'(b_sum), 256);

    // Narrow output: wrap (or clamp with saturation)
    c_iv = 1'b1; c_ops = '1;
    repeat (3) step;
    c_iv = 1'b0;
    n = 0;
    while (!c_ov && n < 10) begin
      step;
      n++;
    end
    if (n == 10) fail_evt("narrow_valid_timeout");
`ifdef CSA_TREE_SATURATE_EN
    chk("narrow_sum_sat", 32'(c_sum), 1023);
    chk("narrow_sat_flag", 32'(c_sat), 1);
`else
    chk("narrow_sum_wrap", 32'(c_sum), 247);
`endif

    // Random traffic against the scoreboard
    rand_on = 1'b1;
    repeat (400) begin
      a_iv  = ($urandom % 4) != 0;
      a_ops = 24'($urandom);
      a_or  = ($urandom % 3) != 0;
      step;
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    repeat (10) step;
    rand_on = 1'b0;
    chk("rand_queue_drained", 32'(q.size()), 0);
    chk("rand_results_seen", 32'(rseen > 20), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
